// File: rtl/ara_pkg.sv
// rtl/ara_pkg.sv - shared types for the AXI read-alignment tracker
//
// align_track_t : one outstanding AR burst as seen by the R-path shifters.
//   offset : AR address low bits, zero-extended to AlignOffsetW
//            (AlignOffsetW = 8 covers data widths up to 2048 bits).
//   valid  : entry holds a burst that stage 0 has not yet retired.
package ara_pkg;

    localparam int unsigned AlignOffsetW = 8;

    typedef struct packed {
        logic [AlignOffsetW-1:0] offset;
        logic                    valid;
    } align_track_t;

endpackage

// File: rtl/align_ctrl.sv
// rtl/align_ctrl.sv - per-stage byte-rotation control for misaligned AXI reads
//
// Optional feature macro: ALIGN_CTRL_PERF_EN (enables perf_shifted_o counter).
//
// Ports:
//   clk_i, rst_ni    clock, asynchronous active-low reset
//   ar_valid_i       upstream AR valid
//   ar_offset_i      AR address low bits (one bit per rotate stage)
//   ar_ready_i       downstream AR ready
//   ar_ready_o       AR ready to upstream (ar_ready_i gated by tracker space)
//   r_last_hs_i      per stage: last R beat of a burst handshaked at that stage
//   shift_en_o       per stage: rotate-by-2^s bytes enable for current burst
//   be_o             byte mask for the burst currently at stage 0
//   full_o, empty_o  tracker occupancy status
//   perf_shifted_o   accepted bursts with nonzero offset (0 when feature off)
module align_ctrl
    import ara_pkg::*;
#(
    parameter int unsigned NumTrackers  = 8,
    parameter int unsigned AxiDataWidth = 64
) (
    input  logic                                  clk_i,
    input  logic                                  rst_ni,
    input  logic                                  ar_valid_i,
    input  logic [$clog2(AxiDataWidth/8)-1:0]     ar_offset_i,
    input  logic                                  ar_ready_i,
    output logic                                  ar_ready_o,
    input  logic [$clog2(AxiDataWidth/8)-1:0]     r_last_hs_i,
    output logic [$clog2(AxiDataWidth/8)-1:0]     shift_en_o,
    output logic [AxiDataWidth/8-1:0]             be_o,
    output logic                                  full_o,
    output logic                                  empty_o,
    output logic [31:0]                           perf_shifted_o
);

    localparam int unsigned StrbW     = AxiDataWidth / 8;
    localparam int unsigned NumStages = $clog2(StrbW);
    localparam int unsigned PtrW      = $clog2(NumTrackers);
    localparam int unsigned CntW      = PtrW + 1;

    align_track_t          entries_q [NumTrackers];
    logic [PtrW-1:0]       wptr_q;
    logic [PtrW-1:0]       rptr_q    [NumStages];
    logic [CntW-1:0]       count_q;

    align_track_t          head      [NumStages];
    logic [NumStages-1:0]  adv;
    logic                  push;
    logic                  pop;

    assign full_o     = (count_q == CntW'(NumTrackers));
    assign empty_o    = (count_q == '0);
    // No bypass: a pop in the same cycle does not free a slot for a push.
    assign ar_ready_o = ar_ready_i & ~full_o;
    assign push       = ar_valid_i & ar_ready_o;
    assign pop        = adv[0];

    // Each stage looks at its own entry; a pulse on an invalid entry is dropped
    // so a stray last-beat can never run a stage pointer past the write pointer.
    always_comb begin
        adv        = '0;
        shift_en_o = '0;
        for (int s = 0; s < NumStages; s++) begin
            head[s]       = entries_q[rptr_q[s]];
            adv[s]        = r_last_hs_i[s] & head[s].valid;
            shift_en_o[s] = head[s].valid & head[s].offset[s];
        end
        be_o = {StrbW{1'b1}};
        if (head[0].valid) begin
            be_o = {StrbW{1'b1}} >> head[0].offset;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < NumTrackers; i++) begin
                entries_q[i] <= '0;
            end
            for (int s = 0; s < NumStages; s++) begin
                rptr_q[s] <= '0;
            end
            wptr_q  <= '0;
            count_q <= '0;
        end else begin
            // Push and pop never target the same slot: pop needs a valid
            // entry (count>0) and push needs a free one (count<NumTrackers).
            if (pop) begin
                entries_q[rptr_q[0]].valid <= 1'b0;
            end
            if (push) begin
                entries_q[wptr_q] <= '{offset: AlignOffsetW'(ar_offset_i), valid: 1'b1};
                wptr_q            <= wptr_q + PtrW'(1);
            end
            for (int s = 0; s < NumStages; s++) begin
                if (adv[s]) begin
                    rptr_q[s] <= rptr_q[s] + PtrW'(1);
                end
            end
            case ({push, pop})
                2'b10:   count_q <= count_q + CntW'(1);
                2'b01:   count_q <= count_q - CntW'(1);
                default: count_q <= count_q;
            endcase
        end
    end

`ifdef ALIGN_CTRL_PERF_EN
    logic [31:0] perf_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            perf_q <= '0;
        end else if (push && (ar_offset_i != '0)) begin
            perf_q <= perf_q + 32'd1;
        end
    end

    assign perf_shifted_o = perf_q;
`else
    assign perf_shifted_o = '0;
`endif

endmodule

// File: tb/tb_align_ctrl.sv
// tb/tb_align_ctrl.sv - directed vector bench for align_ctrl (64-bit, 8 trackers)
module tb_align_ctrl;

    logic       clk_i = 1'b0;
    logic       rst_ni = 1'b0;
    logic       ar_valid_i = 1'b0;
    logic [2:0] ar_offset_i = '0;
    logic       ar_ready_i = 1'b1;
    logic       ar_ready_o;
    logic [2:0] r_last_hs_i = '0;
    logic [2:0] shift_en_o;
    logic [7:0] be_o;
    logic       full_o;
    logic       empty_o;
    logic [31:0] perf_shifted_o;

    int n_cmp = 0;
    int n_bad = 0;

`ifdef ALIGN_CTRL_PERF_EN
    localparam logic [31:0] PerfExp = 32'd2;
`else
    localparam logic [31:0] PerfExp = 32'd0;
`endif

    align_ctrl #(.NumTrackers(8), .AxiDataWidth(64)) dut (
        .clk_i          (clk_i),
        .rst_ni         (rst_ni),
        .ar_valid_i     (ar_valid_i),
        .ar_offset_i    (ar_offset_i),
        .ar_ready_i     (ar_ready_i),
        .ar_ready_o     (ar_ready_o),
        .r_last_hs_i    (r_last_hs_i),
        .shift_en_o     (shift_en_o),
        .be_o           (be_o),
        .full_o         (full_o),
        .empty_o        (empty_o),
        .perf_shifted_o (perf_shifted_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic       vld;
        logic [2:0] off;
        logic [2:0] rl;
        logic [2:0] e_shift;
        logic [7:0] e_be;
        logic       e_full;
        logic       e_empty;
    } vec_t;

    vec_t tbl [12];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic chk_state(input string tag, input logic [2:0] sh, input logic [7:0] be,
                             input logic fu, input logic em);
        chk({tag, ".shift_en"}, 32'(shift_en_o), 32'(sh));
        chk({tag, ".be"},       32'(be_o),       32'(be));
        chk({tag, ".full"},     32'(full_o),     32'(fu));
        chk({tag, ".empty"},    32'(empty_o),    32'(em));
        chk({tag, ".ar_ready"}, 32'(ar_ready_o), 32'(!fu));
    endtask

    // Apply one cycle of stimulus, then return inputs to idle (ar_ready_i=1).
    task automatic cyc(input logic vld, input logic [2:0] off, input logic rdy, input logic [2:0] rl);
        ar_valid_i  = vld;
        ar_offset_i = off;
        ar_ready_i  = rdy;
        r_last_hs_i = rl;
        @(posedge clk_i);
        #1;
        ar_valid_i  = 1'b0;
        ar_offset_i = '0;
        ar_ready_i  = 1'b1;
        r_last_hs_i = '0;
    endtask

    task automatic do_reset();
        rst_ni = 1'b0;
        @(posedge clk_i);
        #1;
        rst_ni = 1'b1;
        #1;
    endtask

    initial begin
        logic [2:0] drain_off [8];

        // Reset values while held in reset.
        ar_ready_i = 1'b0;
        #2;
        chk("rst.ar_ready_lo", 32'(ar_ready_o), 32'd0);
        ar_ready_i = 1'b1;
        #1;
        chk_state("rst", 3'b000, 8'hFF, 1'b0, 1'b1);
        chk("rst.perf", perf_shifted_o, 32'd0);
        @(posedge clk_i);
        #1;
        rst_ni = 1'b1;

        // Fill to full, then retire one burst stage by stage.
        tbl[0]  = '{1'b1, 3'd3, 3'b000, 3'b011, 8'h1F, 1'b0, 1'b0};
        tbl[1]  = '{1'b1, 3'd5, 3'b000, 3'b011, 8'h1F, 1'b0, 1'b0};
        tbl[2]  = '{1'b1, 3'd0, 3'b000, 3'b011, 8'h1F, 1'b0, 1'b0};
        tbl[3]  = '{1'b1, 3'd1, 3'b000, 3'b011, 8'h1F, 1'b0, 1'b0};
        tbl[4]  = '{1'b1, 3'd2, 3'b000, 3'b011, 8'h1F, 1'b0, 1'b0};
        tbl[5]  = '{1'b1, 3'd4, 3'b000, 3'b011, 8'h1F, 1'b0, 1'b0};
        tbl[6]  = '{1'b1, 3'd6, 3'b000, 3'b011, 8'h1F, 1'b0, 1'b0};
        tbl[7]  = '{1'b1, 3'd7, 3'b000, 3'b011, 8'h1F, 1'b1, 1'b0};
        tbl[8]  = '{1'b1, 3'd2, 3'b000, 3'b011, 8'h1F, 1'b1, 1'b0};
        tbl[9]  = '{1'b0, 3'd0, 3'b100, 3'b111, 8'h1F, 1'b1, 1'b0};
        tbl[10] = '{1'b0, 3'd0, 3'b010, 3'b101, 8'h1F, 1'b1, 1'b0};
        tbl[11] = '{1'b0, 3'd0, 3'b001, 3'b101, 8'h07, 1'b0, 1'b0};

        for (int i = 0; i < 12; i++) begin
            cyc(tbl[i].vld, tbl[i].off, 1'b1, tbl[i].rl);
            chk_state($sformatf("tbl%0d", i), tbl[i].e_shift, tbl[i].e_be,
                      tbl[i].e_full, tbl[i].e_empty);
        end

        // Asynchronous reset mid-burst: outputs clear before any clock edge.
        #2;
        rst_ni = 1'b0;
        #1;
        chk_state("async_rst", 3'b000, 8'hFF, 1'b0, 1'b1);
        @(posedge clk_i);
        #1;
        rst_ni = 1'b1;
        #1;

        // Offsets 5 then 2: stage 2 moves on while stage 0 still sees 5.
        cyc(1'b1, 3'd5, 1'b1, 3'b000);
        cyc(1'b1, 3'd2, 1'b1, 3'b000);
        chk_state("s52.init", 3'b101, 8'h07, 1'b0, 1'b0);
        cyc(1'b0, 3'd0, 1'b1, 3'b100);
        chk_state("s52.st2", 3'b001, 8'h07, 1'b0, 1'b0);
        cyc(1'b0, 3'd0, 1'b1, 3'b011);
        chk_state("s52.st10", 3'b010, 8'h3F, 1'b0, 1'b0);
        cyc(1'b0, 3'd0, 1'b1, 3'b111);
        chk_state("s52.all", 3'b000, 8'hFF, 1'b0, 1'b1);

        // Move all pointers to 6, then hold count at 4 across the 7->0 wrap.
        do_reset();
        for (int i = 0; i < 6; i++) cyc(1'b1, 3'd0, 1'b1, 3'b000);
        for (int i = 0; i < 6; i++) cyc(1'b0, 3'd0, 1'b1, 3'b111);
        chk("wrap.empty6", 32'(empty_o), 32'd1);
        cyc(1'b1, 3'd1, 1'b1, 3'b000);   // idx6
        cyc(1'b1, 3'd2, 1'b1, 3'b000);   // idx7
        cyc(1'b1, 3'd4, 1'b1, 3'b000);   // idx0
        cyc(1'b1, 3'd3, 1'b1, 3'b000);   // idx1
        chk_state("wrap.cnt4", 3'b001, 8'h7F, 1'b0, 1'b0);
        cyc(1'b1, 3'd7, 1'b1, 3'b111);   // pop idx6, push idx2
        chk_state("wrap.pp1", 3'b010, 8'h3F, 1'b0, 1'b0);
        cyc(1'b1, 3'd5, 1'b1, 3'b111);   // pop idx7, push idx3
        chk_state("wrap.pp2", 3'b100, 8'h0F, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) cyc(1'b1, 3'd0, 1'b1, 3'b000);
        chk("wrap.cnt7_full", 32'(full_o), 32'd0);
        cyc(1'b1, 3'd0, 1'b1, 3'b000);
        chk("wrap.cnt8_full", 32'(full_o), 32'd1);
        drain_off[0] = 3'd4; drain_off[1] = 3'd3; drain_off[2] = 3'd7; drain_off[3] = 3'd5;
        drain_off[4] = 3'd0; drain_off[5] = 3'd0; drain_off[6] = 3'd0; drain_off[7] = 3'd0;
        for (int i = 0; i < 8; i++) begin
            chk($sformatf("drain%0d.shift", i), 32'(shift_en_o), 32'(drain_off[i]));
            cyc(1'b0, 3'd0, 1'b1, 3'b111);
        end
        chk_state("drain.end", 3'b000, 8'hFF, 1'b0, 1'b1);

        // Pulses while empty are ignored: a later push is seen at stage 0..2.
        do_reset();
        cyc(1'b0, 3'd0, 1'b1, 3'b111);
        chk_state("emptypulse", 3'b000, 8'hFF, 1'b0, 1'b1);
        cyc(1'b1, 3'd7, 1'b1, 3'b000);
        chk_state("emptypulse.push", 3'b111, 8'h01, 1'b0, 1'b0);

        // Perf counter: offsets 0,4,1 accepted, then a blocked push of 6.
        do_reset();
        chk("perf.rst", perf_shifted_o, 32'd0);
        cyc(1'b1, 3'd0, 1'b1, 3'b000);
        cyc(1'b1, 3'd4, 1'b1, 3'b000);
        cyc(1'b1, 3'd1, 1'b1, 3'b000);
        chk("perf.three", perf_shifted_o, PerfExp);
        cyc(1'b1, 3'd6, 1'b0, 3'b000);
        chk("perf.blocked", perf_shifted_o, PerfExp);
        chk("perf.blocked_head", 32'(shift_en_o), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
